// File: rtl/cla_pkg.sv
// Shared types for the 4-bit carry-lookahead adder: operand width, nibble type
// and the packed result bundle produced by the combinational lookahead core.
package cla_pkg;

  localparam int unsigned CLA_W = 4;

  typedef logic [CLA_W-1:0] nib_t;

  typedef struct packed {
    nib_t sum;
    logic cout;
    logic gg;
    logic gp;
  } cla_res_t;

endpackage

// File: rtl/cla_4bit_logic.sv
// Combinational 4-bit carry-lookahead core: every carry is a flat
// sum-of-products of generate/propagate terms and cin, never a chain.
module cla_4bit_logic
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output cla_res_t         res
);

  logic [CLA_W-1:0] g;
  logic [CLA_W-1:0] p;
  logic [CLA_W:0]   c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    res.sum  = p ^ c[CLA_W-1:0];
    res.cout = c[CLA_W];
    // Group terms exclude cin so a parent lookahead unit can combine them.
    res.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    res.gp   = &p;
  end

endmodule

// File: rtl/cla_4bit.sv
// Registered 4-bit carry-lookahead adder with optional input stage (IN_REG).
// Define CLA_4BIT_OVF_EN to add the registered signed-overflow output ovf.
module cla_4bit
  import cla_pkg::*;
#(
  parameter int unsigned IN_REG = 0
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [CLA_W-1:0] sum,
  output logic             cout,
  output logic             gg,
  output logic             gp
`ifdef CLA_4BIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic stg_valid;
  nib_t stg_a;
  nib_t stg_b;
  logic stg_cin;

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic in_valid_d, in_valid_q;
      nib_t a_d, a_q, b_d, b_q;
      logic cin_d, cin_q;

      always_comb begin
        in_valid_d = in_valid;
        a_d        = a;
        b_d        = b;
        cin_d      = cin;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          in_valid_q <= 1'b0;
          a_q        <= '0;
          b_q        <= '0;
          cin_q      <= 1'b0;
        end else begin
          in_valid_q <= in_valid_d;
          a_q        <= a_d;
          b_q        <= b_d;
          cin_q      <= cin_d;
        end
      end

      assign stg_valid = in_valid_q;
      assign stg_a     = a_q;
      assign stg_b     = b_q;
      assign stg_cin   = cin_q;
    end else begin : g_no_in_reg
      assign stg_valid = in_valid;
      assign stg_a     = a;
      assign stg_b     = b;
      assign stg_cin   = cin;
    end
  endgenerate

  cla_res_t res_c;
  cla_res_t res_d, res_q;
  logic     out_valid_d, out_valid_q;

  cla_4bit_logic u_logic (
    .a   (stg_a),
    .b   (stg_b),
    .cin (stg_cin),
    .res (res_c)
  );

  // Result registers load on valid and hold otherwise; valid itself tracks every cycle.
  always_comb begin
    out_valid_d = stg_valid;
    res_d       = res_q;
    if (stg_valid) begin
      res_d = res_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = res_q.sum;
  assign cout      = res_q.cout;
  assign gg        = res_q.gg;
  assign gp        = res_q.gp;

`ifdef CLA_4BIT_OVF_EN
  logic ovf_c, ovf_d, ovf_q;

  // c3 is recovered as p3 ^ sum3, so ovf = c4 ^ c3.
  always_comb begin
    ovf_c = res_c.cout ^ stg_a[CLA_W-1] ^ stg_b[CLA_W-1] ^ res_c.sum[CLA_W-1];
    ovf_d = ovf_q;
    if (stg_valid) begin
      ovf_d = ovf_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_4bit.sv
// Self-checking bench for cla_4bit: drives IN_REG=0 and IN_REG=1 instances in
// parallel, with per-instance expected-result queues and held-value models.
module tb_cla_4bit;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       gg;
    logic       gp;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;

  logic       out_valid0, cout0, gg0, gp0;
  logic [3:0] sum0;
  logic       out_valid1, cout1, gg1, gp1;
  logic [3:0] sum1;
`ifdef CLA_4BIT_OVF_EN
  logic       ovf0, ovf1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t hold0 = '0;
  exp_t hold1 = '0;
  logic stage_v = 1'b0;

  always #5 clk = ~clk;

  cla_4bit #(.IN_REG(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid0),
    .sum       (sum0),
    .cout      (cout0),
    .gg        (gg0),
    .gp        (gp0)
`ifdef CLA_4BIT_OVF_EN
    ,
    .ovf       (ovf0)
`endif
  );

  cla_4bit #(.IN_REG(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid1),
    .sum       (sum1),
    .cout      (cout1),
    .gg        (gg1),
    .gp        (gp1)
`ifdef CLA_4BIT_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference from integer arithmetic, independent of the lookahead equations.
  function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
    exp_t e;
    int s, sa, sb, ss;
    s      = int'(ma) + int'(mb) + int'(mc);
    e.sum  = s[3:0];
    e.cout = (s > 15);
    e.gg   = (int'(ma) + int'(mb)) > 15;
    e.gp   = ((ma ^ mb) == 4'hF);
    sa     = ma[3] ? int'(ma) - 16 : int'(ma);
    sb     = mb[3] ? int'(mb) - 16 : int'(mb);
    ss     = sa + sb + int'(mc);
    e.ovf  = (ss > 7) || (ss < -8);
    return e;
  endfunction

  // Inputs change on the falling edge; a result is expected only when sampled out of reset.
  task automatic step(input logic r, input logic v, input logic [3:0] sa, input logic [3:0] sb,
                      input logic sc, input exp_t e);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = sa;
    b        = sb;
    cin      = sc;
    if (v && !r) begin
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom), '0);
    end
  endtask

  // Output monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      hold0 = '0;
      check("valid0_rst", 32'(out_valid0), 32'd0);
    end else begin
      check("valid0", 32'(out_valid0), 32'(in_valid));
      if (in_valid) begin
        check("q0_nonempty", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0) hold0 = q0.pop_front();
      end
    end
    check("res0", 32'({sum0, cout0, gg0, gp0}), 32'({hold0.sum, hold0.cout, hold0.gg, hold0.gp}));
`ifdef CLA_4BIT_OVF_EN
    check("ovf0", 32'(ovf0), 32'(hold0.ovf));
`endif

    if (rst) begin
      if (stage_v && q1.size() > 0) void'(q1.pop_front());
      stage_v = 1'b0;
      hold1   = '0;
      check("valid1_rst", 32'(out_valid1), 32'd0);
    end else begin
      check("valid1", 32'(out_valid1), 32'(stage_v));
      if (stage_v) begin
        check("q1_nonempty", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) hold1 = q1.pop_front();
      end
      stage_v = in_valid;
    end
    check("res1", 32'({sum1, cout1, gg1, gp1}), 32'({hold1.sum, hold1.cout, hold1.gg, hold1.gp}));
`ifdef CLA_4BIT_OVF_EN
    check("ovf1", 32'(ovf1), 32'(hold1.ovf));
`endif
  end

  vec_t tbl[8];

  initial begin
    // fields: sum, cout, gg, gp, ovf
    tbl[0] = '{4'b0011, 4'b0111, 1'b0, '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[1] = '{4'b0111, 4'b1010, 1'b0, '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{4'b1111, 4'b1111, 1'b1, '{4'b1111, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[3] = '{4'b1111, 4'b0000, 1'b1, '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{4'b0111, 4'b0001, 1'b0, '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{4'b1000, 4'b1000, 1'b0, '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b1}};
    tbl[7] = '{4'b0101, 4'b1010, 1'b0, '{4'b1111, 1'b0, 1'b0, 1'b1, 1'b0}};

    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 4'hF;
    b        = 4'hF;
    cin      = 1'b1;
    // Reset held two cycles with in_valid high: nothing may come out.
    step(1'b1, 1'b1, 4'h9, 4'h6, 1'b1, '0);

    // Directed vectors back-to-back right after reset release.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].e);
    end

    // Inputs wander with in_valid low: outputs must hold.
    idle(5);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step(1'b0, 1'b1, v[3:0], v[7:4], v[8], model(v[3:0], v[7:4], v[8]));
      if ((i % 97) == 96) idle(1);
    end
    idle(3);

    // Reset mid-stream with valid traffic in flight.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'(i + 5), 4'(9 - i), 1'(i), model(4'(i + 5), 4'(9 - i), 1'(i)));
    end
    step(1'b1, 1'b1, 4'hA, 4'hB, 1'b1, '0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      step(1'b0, 1'b1, ra, rb, rc, model(ra, rb, rc));
    end
    idle(4);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_4bit.md
Name: cla_4bit

Overview:
4-bit carry-lookahead adder with registered outputs. It computes a + b + cin using generate/propagate lookahead, so no carry ripples through the bits. It also exports group generate/propagate so it can be cascaded into wider adders. Used as a leaf arithmetic block in datapaths that need a clean, registered sum and carry.

Parameters:
IN_REG, 0, 1 = register a/b/cin/in_valid before the lookahead logic (latency 2); 0 = feed inputs straight into the logic (latency 1).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  qualifies a/b/cin this cycle
a  input  4  operand A, unsigned
b  input  4  operand B, unsigned
cin  input  1  carry in
out_valid  output  1  sum/cout/gg/gp hold a valid result
sum  output  4  (a+b+cin) mod 16
cout  output  1  carry out of bit 3
gg  output  1  group generate G3 | P3G2 | P3P2G1 | P3P2P1G0
gp  output  1  group propagate P3&P2&P1&P0

Behaviour:
- Per bit i: g[i] = a[i]&b[i]; p[i] = a[i]^b[i].
- Carries: c0 = cin; c[i+1] = g[i] | p[i]&c[i], each expanded into sum-of-products form (no chained dependency). cout = c4.
- sum[i] = p[i] ^ c[i].
- Result must equal the integer sum: {cout,sum} = a + b + cin for all 512 input combinations.
- Output registers: out_valid, sum, cout, gg, gp are all flip-flops.
- Reset (rst=1 at a clk edge): out_valid=0, sum=0, cout=0, gg=0, gp=0. The IN_REG input stage, when present, also clears to 0. Reset takes priority over in_valid in the same cycle.
- Latency: 1 cycle when IN_REG=0; 2 cycles when IN_REG=1. Throughput is 1 operation per cycle, with no stalls and no backpressure.
- Result registers load only when the (possibly registered) valid bit is 1. Otherwise they hold their previous value. out_valid follows the valid bit every cycle.
- Reset deasserted mid-stream: the first valid output appears exactly one latency after the first in_valid sampled after reset.
- Boundaries:
  - 15+15+1 gives sum=1111, cout=1.
  - 0+0+0 gives sum=0000, cout=0, gg=0, gp=0.
  - 1111+0000 gives gp=1, gg=0.
  - X on inputs while in_valid=0 must not corrupt the held outputs.

Optional Feature:
Macro CLA_4BIT_OVF_EN.
- Defined: adds output port ovf (1 bit) = c4 ^ c3, the two's-complement signed overflow. It is registered alongside sum, resets to 0, and follows the same load/hold rule.
- Undefined: the port and its logic are absent; the rest of the behaviour is unchanged.

Decomposition:
- Shared package cla_pkg holds:
  - localparam CLA_W = 4
  - typedef logic [CLA_W-1:0] nib_t
  - a packed struct cla_res_t {nib_t sum; logic cout, gg, gp;}
- One natural sub-module, cla_4bit_logic: purely combinational, inputs a/b/cin, outputs cla_res_t. cla_4bit wraps it with the optional input stage and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> all outputs 0 and out_valid=0. Release rst -> first valid result after the configured latency.
- a=0011, b=0111, cin=0, in_valid=1 -> after latency: sum=1010 (10), cout=0, out_valid=1.
- a=0111, b=1010, cin=0 -> sum=0001, cout=1 (17). Back-to-back with the previous vector, results appear on consecutive cycles.
- a=1111, b=1111, cin=1 -> sum=1111, cout=1, gg=1, gp=0. Also a=1111, b=0000, cin=1 -> sum=0000, cout=1, gp=1, gg=0.
- Exhaustive sweep of all 512 a/b/cin combinations at IN_REG=0 and IN_REG=1 -> {cout,sum} matches a+b+cin. With CLA_4BIT_OVF_EN defined, also check a=0111, b=0001 -> ovf=1.
- in_valid=0 with changing a/b -> sum/cout hold their last values and out_valid=0. Assert rst mid-stream -> outputs clear on the next edge.
